// File: rtl/rf_write_scheduler_if.sv
// Writeback bus between the requesters/decode and the register-file write scheduler.
interface rf_write_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_addr;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [31:0]       busy;
  logic              grant_b;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, rsv_valid, rsv_addr,
    input  a_ready, b_ready, rf_we, rf_waddr, rf_wdata, busy, grant_b
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, rsv_valid, rsv_addr,
    output a_ready, b_ready, rf_we, rf_waddr, rf_wdata, busy, grant_b
  );
endinterface

// File: rtl/rf_write_scheduler.sv
// Shares the register-file write port between ALU (A) and load (B) writebacks via
// per-side FIFOs and round-robin arbitration; also keeps the RAW busy scoreboard.

module rf_write_scheduler_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              ready,
  output logic              nonempty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push_ok;
  logic              pop_ok;

  // Ready comes only from the registered count: no same-cycle pop bypass.
  assign ready     = (count != CNT_W'(DEPTH));
  assign nonempty  = (count != '0);
  assign push_ok   = push && ready;
  assign pop_ok    = pop && nonempty;
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
      else if (!push_ok && pop_ok) count <= count - CNT_W'(1);
    end
  end
endmodule

module rf_write_scheduler #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input logic                  clk,
  input logic                  rst,
  rf_write_scheduler_if.slave  bus
);
  logic              a_ne, b_ne;
  logic [ADDR_W-1:0] a_head_addr, b_head_addr;
  logic [DATA_W-1:0] a_head_data, b_head_data;
  logic              gnt_a, gnt_b, gnt_any;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  logic              fav_b;
  logic              we_q, grant_b_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [31:0]       busy_q, busy_next;

  rf_write_scheduler_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.a_valid),
    .push_addr (bus.a_addr),
    .push_data (bus.a_data),
    .pop       (gnt_a),
    .ready     (bus.a_ready),
    .nonempty  (a_ne),
    .head_addr (a_head_addr),
    .head_data (a_head_data)
  );

  rf_write_scheduler_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.b_valid),
    .push_addr (bus.b_addr),
    .push_data (bus.b_data),
    .pop       (gnt_b),
    .ready     (bus.b_ready),
    .nonempty  (b_ne),
    .head_addr (b_head_addr),
    .head_data (b_head_data)
  );

  assign gnt_a    = a_ne && (!b_ne || !fav_b);
  assign gnt_b    = b_ne && (!a_ne || fav_b);
  assign gnt_any  = gnt_a || gnt_b;
  assign gnt_addr = gnt_b ? b_head_addr : a_head_addr;
  assign gnt_data = gnt_b ? b_head_data : a_head_data;

  // Clear lands on the edge that raises rf_we; a same-edge reserve is a newer producer and wins.
  always_comb begin
    busy_next = busy_q;
    if (gnt_any) busy_next[gnt_addr] = 1'b0;
    if (bus.rsv_valid) busy_next[bus.rsv_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fav_b     <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      grant_b_q <= 1'b0;
      busy_q    <= '0;
    end else begin
      if (a_ne && b_ne) fav_b <= !fav_b;
      // r0 entries are consumed but never written.
      we_q      <= gnt_any && (gnt_addr != '0);
      grant_b_q <= gnt_b;
      if (gnt_any) begin
        waddr_q <= gnt_addr;
        wdata_q <= gnt_data;
      end
      busy_q    <= busy_next;
    end
  end

  assign bus.rf_we    = we_q;
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;
  assign bus.grant_b  = grant_b_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_rf_write_scheduler.sv
// Bench for rf_write_scheduler: hand-written vector table, directed corner sequences,
// and random traffic against a queue-based reference model.
module tb_rf_write_scheduler;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_write_scheduler_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  rf_write_scheduler #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one queue per requester, plus who won the last contest.
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        qa[$];
  ent_t        qb[$];
  bit          last_contest_a;
  bit          m_we;
  bit          m_gb;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_busy;

  task automatic model_reset();
    qa.delete();
    qb.delete();
    last_contest_a = 1'b0;
    m_we = 1'b0;
    m_gb = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_busy = '0;
  endtask

  // One clock cycle: drive, check readiness, advance the model, clock, check outputs.
  task automatic cycle(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                       input bit rv, input logic [4:0] ra,
                       output bit acc_a, output bit acc_b);
    ent_t e;
    bit   have;
    bit   from_b;
    bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
    bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
    bus.rsv_valid = rv; bus.rsv_addr = ra;
    chk("a_ready", bus.a_ready, qa.size() < DEPTH);
    chk("b_ready", bus.b_ready, qb.size() < DEPTH);
    acc_a = av && (qa.size() < DEPTH);
    acc_b = bv && (qb.size() < DEPTH);
    have = 1'b1;
    from_b = 1'b0;
    if (qa.size() > 0 && qb.size() > 0) begin
      from_b = last_contest_a;
      last_contest_a = !from_b;
    end else if (qa.size() > 0) from_b = 1'b0;
    else if (qb.size() > 0) from_b = 1'b1;
    else have = 1'b0;
    m_gb = have && from_b;
    m_we = 1'b0;
    if (have) begin
      e = from_b ? qb.pop_front() : qa.pop_front();
      m_we = (e.addr != 0);
      m_waddr = e.addr;
      m_wdata = e.data;
      m_busy[e.addr] = 1'b0;
    end
    if (rv && ra != 0) m_busy[ra] = 1'b1;
    if (acc_a) qa.push_back('{addr: aa, data: ad});
    if (acc_b) qb.push_back('{addr: ba, data: bd});
    @(posedge clk); #1;
    chk("rf_we", bus.rf_we, m_we);
    chk("grant_b", bus.grant_b, m_gb);
    chk("busy", bus.busy, m_busy);
    if (m_we) begin
      chk("rf_waddr", bus.rf_waddr, m_waddr);
      chk("rf_wdata", bus.rf_wdata, m_wdata);
    end
  endtask

  task automatic idle(input int n);
    bit x, y;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, x, y);
  endtask

  task automatic do_reset();
    bus.a_valid = 0; bus.b_valid = 0; bus.rsv_valid = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit          av; logic [4:0] aa; logic [31:0] ad;
    bit          bv; logic [4:0] ba; logic [31:0] bd;
    bit          rv; logic [4:0] ra;
    bit          e_we; logic [4:0] e_waddr; logic [31:0] e_wdata;
    bit          e_gb; logic [31:0] e_busy;
  } vec_t;

  vec_t tbl[13];
  int   order[8];
  int   log_addr[8];

  initial begin
    bit acc_a, acc_b;
    int ai, bi, nw;
    logic [31:0] b7;
    b7 = 32'h0000_0080;

    // av aa ad | bv ba bd | rv ra || we waddr wdata gb busy
    tbl[0]  = '{1, 5, 1234,         0, 0, 0,  0, 0,  0, 0, 0,            0, 0};
    tbl[1]  = '{0, 0, 0,            0, 0, 0,  0, 0,  1, 5, 1234,         0, 0};
    tbl[2]  = '{0, 0, 0,            0, 0, 0,  1, 7,  0, 0, 0,            0, b7};
    tbl[3]  = '{1, 7, 32'hFFFFFFFB, 0, 0, 0,  0, 0,  0, 0, 0,            0, b7};
    tbl[4]  = '{0, 0, 0,            0, 0, 0,  0, 0,  1, 7, 32'hFFFFFFFB, 0, 0};
    tbl[5]  = '{1, 7, 3,            0, 0, 0,  1, 7,  0, 0, 0,            0, b7};
    tbl[6]  = '{0, 0, 0,            0, 0, 0,  1, 7,  1, 7, 3,            0, b7};
    tbl[7]  = '{0, 0, 0,            0, 0, 0,  0, 0,  0, 0, 0,            0, b7};
    tbl[8]  = '{1, 0, 99,           0, 0, 0,  0, 0,  0, 0, 0,            0, b7};
    tbl[9]  = '{0, 0, 0,            0, 0, 0,  0, 0,  0, 0, 0,            0, b7};
    tbl[10] = '{0, 0, 0,            0, 0, 0,  1, 0,  0, 0, 0,            0, b7};
    tbl[11] = '{0, 0, 0,            1, 9, 77, 0, 0,  0, 0, 0,            0, b7};
    tbl[12] = '{0, 0, 0,            0, 0, 0,  0, 0,  1, 9, 77,           1, b7};

    bus.a_valid = 0; bus.a_addr = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_addr = 0; bus.b_data = 0;
    bus.rsv_valid = 0; bus.rsv_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf_we", bus.rf_we, 0);
    chk("reset_waddr", bus.rf_waddr, 0);
    chk("reset_wdata", bus.rf_wdata, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_grant_b", bus.grant_b, 0);
    chk("reset_a_ready", bus.a_ready, 1);
    chk("reset_b_ready", bus.b_ready, 1);
    rst = 1'b0;
    model_reset();

    // Hand-computed table.
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd,
            tbl[i].rv, tbl[i].ra, acc_a, acc_b);
      chk($sformatf("tbl%0d_we", i), bus.rf_we, tbl[i].e_we);
      chk($sformatf("tbl%0d_gb", i), bus.grant_b, tbl[i].e_gb);
      chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].e_busy);
      if (tbl[i].e_we) begin
        chk($sformatf("tbl%0d_waddr", i), bus.rf_waddr, tbl[i].e_waddr);
        chk($sformatf("tbl%0d_wdata", i), bus.rf_wdata, tbl[i].e_wdata);
      end
    end

    // Both requesters streaming: writes must alternate starting with A.
    do_reset();
    order = '{1, 11, 2, 12, 3, 13, 4, 14};
    ai = 0; bi = 0; nw = 0;
    for (int c = 0; c < 40 && nw < 8; c++) begin
      cycle(ai < 4, 5'(1 + ai), 32'(100 + ai), bi < 4, 5'(11 + bi), 32'(200 + bi),
            0, 0, acc_a, acc_b);
      if (acc_a) ai++;
      if (acc_b) bi++;
      if (bus.rf_we) begin
        log_addr[nw] = int'(bus.rf_waddr);
        nw++;
      end
    end
    chk("stream_write_count", nw, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("stream_order%0d", i), log_addr[i], order[i]);

    // B backpressure under contention: third beat must wait for a pop.
    do_reset();
    cycle(1, 21, 1, 1, 31, 11, 0, 0, acc_a, acc_b);
    chk("bp_b_acc0", acc_b, 1);
    cycle(1, 22, 2, 1, 32, 12, 0, 0, acc_a, acc_b);
    chk("bp_b_acc1", acc_b, 1);
    cycle(0, 0, 0, 1, 33, 13, 0, 0, acc_a, acc_b);
    chk("bp_b_ready_low", bus.b_ready === 1'b0 || acc_b == 0, 1);
    chk("bp_b_acc2", acc_b, 0);
    cycle(0, 0, 0, 1, 33, 13, 0, 0, acc_a, acc_b);
    chk("bp_b_acc3", acc_b, 1);
    idle(6);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      cycle($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), acc_a, acc_b);
    end
    idle(6);

    // Asynchronous reset in the middle of a cycle with traffic in flight.
    cycle(1, 3, 33, 1, 4, 44, 1, 3, acc_a, acc_b);
    cycle(1, 5, 55, 1, 6, 66, 1, 5, acc_a, acc_b);
    cycle(1, 8, 88, 1, 9, 99, 1, 8, acc_a, acc_b);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rf_we", bus.rf_we, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_a_ready", bus.a_ready, 1);
    chk("arst_b_ready", bus.b_ready, 1);
    chk("arst_grant_b", bus.grant_b, 0);
    chk("arst_waddr", bus.rf_waddr, 0);
    bus.a_valid = 0; bus.b_valid = 0; bus.rsv_valid = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
- Owns the register file's single write port (valid_opcode / addr3 / in) and shares it between two writeback requesters: ALU result (port A) and load result (port B).
- Each requester is buffered in its own 2-entry FIFO, and the FIFO heads are arbitrated round-robin, one register-file write per cycle.
- A 32-bit busy scoreboard tracks destination registers reserved at issue and not yet written back. Decode uses it for RAW stall detection.

Parameters:
- DATA_W, 32, write data width (signed, two's complement)
- ADDR_W, 5, register address width (32 registers)
- FIFO_DEPTH, 2, entries per requester FIFO (power of 2, minimum 2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- a_valid  in  1  ALU writeback request
- a_ready  out  1  A FIFO not full; transfer occurs when a_valid && a_ready
- a_addr  in  ADDR_W  A destination register
- a_data  in  DATA_W  A write data
- b_valid  in  1  load writeback request
- b_ready  out  1  B FIFO not full
- b_addr  in  ADDR_W  B destination register
- b_data  in  DATA_W  B write data
- rsv_valid  in  1  decode reserves a destination register
- rsv_addr  in  ADDR_W  register being reserved
- rf_we  out  1  drives register file valid_opcode
- rf_waddr  out  ADDR_W  drives register file addr3
- rf_wdata  out  DATA_W  drives register file in
- busy  out  32  scoreboard; bit i = register i has a pending write
- grant_b  out  1  registered; 1 = the current rf_we write came from B

Behaviour:
- Reset (async, immediate):
  - rf_we=0, rf_waddr=0, rf_wdata=0, grant_b=0, busy=0.
  - Both FIFOs empty, so a_ready=b_ready=1.
  - Round-robin pointer is set to favour A.
- FIFOs:
  - Push on valid&&ready. Pop when that head is granted.
  - Push and pop in the same cycle on a full FIFO is not allowed: ready is computed from the registered count only, with no same-cycle pop bypass.
  - Pointers wrap modulo FIFO_DEPTH. Count is held in a separate register to tell full from empty.
- Arbitration (combinational over the heads, result registered):
  - Exactly one head non-empty: it is granted.
  - Both heads non-empty: grant the side not granted last. The pointer flips only when a contested grant is made.
  - Neither non-empty: rf_we=0 next cycle.
- Output register (registered outputs):
  - A grant in cycle N gives rf_we=1 with that head's addr/data in cycle N+1. The register file commits at the end of N+1.
  - Minimum latency from handshake to RF commit: 2 edges. Push at edge N, grant in N+1, rf_we high in N+2 (a FIFO is not bypassed).
- Register 0 handling:
  - An entry with addr==0 is granted and popped normally, but rf_we stays 0 for it (r0 is hardwired zero).
  - busy[0] is never set.
- Scoreboard:
  - rsv_valid sets busy[rsv_addr] at the next edge.
  - An issued write (the cycle rf_we goes high) clears busy[rf_waddr] at that same edge.
  - Reserve and clear of the same register on the same edge: set wins, because a newer producer is pending.
  - Clearing a register that is not busy is harmless.
- Ordering:
  - Writes from one requester commit in push order.
  - Writes from different requesters to the same register commit in grant order. Decode must not issue a second producer while busy=1, so this order is never observable.
- Reset mid-operation: FIFO contents and pending busy bits are discarded with no write issued. The in-flight rf_we drops asynchronously.

Test Plan:
- Reset, then A pushes (addr 5, data 1234) alone -> rf_we=1, rf_waddr=5, rf_wdata=1234 exactly 2 edges after the handshake; r5 reads 1234; grant_b=0.
- A and B both push continuously (A to r1..r4, B to r11..r14) -> rf_we alternates A,B,A,B starting with A; all 8 writes land; a_ready/b_ready never both stuck low.
- B valid for 3 back-to-back cycles with no grants (force A contention) -> b_ready falls after 2 pushes; the 3rd beat is held until a pop; no data lost or reordered.
- rsv_valid for r7, then A writes r7 (data -5) -> busy[7]=1 until the rf_we edge, then 0; r7 reads -5 (0xFFFFFFFB). Repeat with rsv of r7 on the same edge as its write -> busy[7] stays 1.
- A pushes addr 0 with data 99 -> entry pops, rf_we stays 0, r0 reads 0, busy[0]=0.
- Fill both FIFOs and set busy bits, assert rst asynchronously mid-cycle -> rf_we=0 immediately, busy=0, a_ready=b_ready=1, no register modified.
